mitchell_log_multiplier: RTL and testbench

- Pipelined unsigned approximate multiplier using Mitchell's logarithmic method.
- Takes two WIDTH-bit operands through a valid/ready handshake and finds each operand's leading-one position k.
- Forms log2 approximations k + frac, adds them, and converts the sum back to a 2*WIDTH-bit product with an antilog shift.
- Sits directly downstream of the leading-one detector stage, which it instantiates per operand. Its output feeds the approximate-multiplier test harness.

---
 rtl/mitchell_pkg.sv | 37 +++
 rtl/leading_one_detector.sv | 23 ++
 rtl/mitchell_log_multiplier.sv | 130 +++++++++++++
 tb/tb_mitchell_log_multiplier.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mitchell_pkg.sv
// Shared width helpers and pipeline stage payload types for the Mitchell log multiplier.
// Stage structs are sized for the widest legal operand; narrower builds tie the upper bits to zero.
package mitchell_pkg;

  localparam int unsigned MaxWidth = 32;

  function automatic int unsigned f_of(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned kw_of(input int unsigned width);
    return $clog2(width);
  endfunction

  function automatic int unsigned ew_of(input int unsigned width);
    return kw_of(width) + 1;
  endfunction

  localparam int unsigned MaxF  = f_of(MaxWidth);
  localparam int unsigned MaxKw = kw_of(MaxWidth);
  localparam int unsigned MaxEw = ew_of(MaxWidth);

  typedef struct packed {
    logic [MaxKw-1:0] ka;
    logic [MaxKw-1:0] kb;
    logic [MaxF-1:0]  xa;
    logic [MaxF-1:0]  xb;
    logic             zero;
  } s1_t;

  typedef struct packed {
    logic [MaxEw:0] e;
    logic [MaxF:0]  m;
    logic           zero;
  } s2_t;

endpackage

// File: rtl/leading_one_detector.sv
// Combinational leading-one detector: reports the index of the most significant set bit.
// An all-zero input reports position 0; callers flag zero operands separately.
module leading_one_detector
  import mitchell_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]          data_i,
  output logic [kw_of(WIDTH)-1:0]   pos_o
);

  localparam int unsigned KW = kw_of(WIDTH);

  always_comb begin
    pos_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        pos_o = KW'(i);
      end
    end
  end

endmodule

// File: rtl/mitchell_log_multiplier.sv
// Three-stage pipelined unsigned approximate multiplier (Mitchell logarithmic method):
// normalise -> add logarithms -> antilog shift, with valid/ready flow control and no skid buffer.
module mitchell_log_multiplier
  import mitchell_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);

  localparam int unsigned F   = f_of(WIDTH);
  localparam int unsigned KW  = kw_of(WIDTH);
  localparam int unsigned EW  = ew_of(WIDTH);
  localparam int unsigned EW1 = EW + 1;
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [KW-1:0] FPos = KW'(F);
  localparam logic [EW:0]   FExp = EW1'(F);

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [PW-1:0] prod_d, prod_q;

  // A stage loads when empty or when its successor drains it this cycle.
  assign ld3      = ~v3_q | out_ready;
  assign ld2      = ~v2_q | ld3;
  assign ld1      = ~v1_q | ld2;
  assign in_ready = ld1;

  // ---------------- S1: normalise ----------------
  logic [KW-1:0]    ka, kb;
  logic [WIDTH-1:0] sha, shb;

  leading_one_detector #(
    .WIDTH (WIDTH)
  ) u_lod_a (
    .data_i (in_a),
    .pos_o  (ka)
  );

  leading_one_detector #(
    .WIDTH (WIDTH)
  ) u_lod_b (
    .data_i (in_b),
    .pos_o  (kb)
  );

  // Left-align so the leading one sits at bit F; it is absent only for a zero operand.
  assign sha = in_a << (FPos - ka);
  assign shb = in_b << (FPos - kb);

  always_comb begin
    s1_d            = '0;
    s1_d.ka[KW-1:0] = ka;
    s1_d.kb[KW-1:0] = kb;
    s1_d.xa[F-1:0]  = sha[F-1:0];
    s1_d.xb[F-1:0]  = shb[F-1:0];
    s1_d.zero       = ~sha[F] | ~shb[F];
  end

  // ---------------- S2: log add ----------------
  logic [F:0]    sum;
  logic [EW:0]   e_sum;

  assign sum   = {1'b0, s1_q.xa[F-1:0]} + {1'b0, s1_q.xb[F-1:0]};
  assign e_sum = {2'b00, s1_q.ka[KW-1:0]} + {2'b00, s1_q.kb[KW-1:0]} + {{EW{1'b0}}, sum[F]};

  always_comb begin
    s2_d           = '0;
    s2_d.e[EW:0]   = e_sum;
    s2_d.m[F:0]    = {1'b1, sum[F-1:0]};
    s2_d.zero      = s1_q.zero;
  end

  // ---------------- S3: antilog ----------------
  logic [EW:0]  e3;
  logic [PW-1:0] m3;

  assign e3 = s2_q.e[EW:0];
  assign m3 = {{WIDTH{1'b0}}, s2_q.m[F:0]};

  // (m << e) >> F split by direction so no wider intermediate is needed.
  always_comb begin
    prod_d = '0;
    if (!s2_q.zero) begin
      if (e3 >= FExp) begin
        prod_d = m3 << (e3 - FExp);
      end else begin
        prod_d = m3 >> (FExp - e3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      prod_q <= '0;
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld1 && in_valid) s1_q <= s1_d;
      if (ld2 && v1_q)     s2_q <= s2_d;
      if (ld3 && v2_q)     prod_q <= prod_d;
    end
  end

  // Upper struct bits exist only for wider builds and are constant zero here.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{s1_q, s2_q};

  assign out_valid   = v3_q;
  assign out_product = prod_q;

endmodule

// File: tb/tb_mitchell_log_multiplier.sv
// Directed and randomised checks of the Mitchell multiplier: exact-cycle latency, zero and
// power-of-two operands, streaming, backpressure hold, random bubbles and mid-flight reset.
module tb_mitchell_log_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_product;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    longint     p;
  } item_t;

  item_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          n_out = 0;
  logic        hold_armed = 1'b0;
  logic [15:0] held = '0;

  always #5 clk = ~clk;

  mitchell_log_multiplier #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Mitchell reference: P = 2^(ka+kb) * (1 + fa + fb), or 2^(ka+kb+1) * (fa + fb) on carry.
  function automatic longint model(input logic [7:0] a, input logic [7:0] b);
    int     ka, kb;
    longint fa, fb, s;
    if (a == 0 || b == 0) return 0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = (longint'(a) - (longint'(1) << ka)) << (7 - ka);
    fb = (longint'(b) - (longint'(1) << kb)) << (7 - kb);
    s  = fa + fb;
    if (s < 128) return ((128 + s) << (ka + kb)) >> 7;
    return (s << (ka + kb + 1)) >> 7;
  endfunction

  // One clock of traffic: drive, sample at the falling edge, score, then advance past the edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy, output logic rdy_seen, output logic ov_seen);
    item_t  it;
    longint ex, obs;
    logic   ok;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    @(negedge clk);
    rdy_seen = in_ready;
    ov_seen  = out_valid;
    if (hold_armed && out_valid) chk("hold_stable", out_product, held);
    hold_armed = out_valid && !out_ready;
    held       = out_product;
    if (out_valid && out_ready) begin
      n_out++;
      chk("out_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        it  = exp_q.pop_front();
        chk("product", out_product, it.p);
        ex  = longint'(it.a) * longint'(it.b);
        obs = longint'(out_product);
        ok  = (obs <= ex) && ((ex - obs) * 9 <= ex);
        chk("err_bound", ok, 1'b1);
      end
    end
    if (in_valid && in_ready) begin
      it.a = in_a;
      it.b = in_b;
      it.p = model(in_a, in_b);
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  // Single pair into an empty pipeline; result must appear on exactly the third edge.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input longint expv);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    #1;
    chk("one_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("one_lat1_idle", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("one_lat2_idle", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("one_lat3_valid", out_valid, 1'b1);
    chk("one_product", out_product, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       rs, os;
    logic [7:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_product", out_product, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    run_one(8'd12,  8'd10,  112);
    run_one(8'd3,   8'd3,   8);
    run_one(8'd255, 8'd255, 65024);
    run_one(8'd1,   8'd1,   1);
    run_one(8'd0,   8'd200, 0);
    run_one(8'd200, 8'd0,   0);
    run_one(8'd64,  8'd37,  2368);
    run_one(8'd128, 8'd128, 16384);

    // Back-to-back streaming with no backpressure.
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cycle(1'b1, ra, rb, 1'b1, rs, os);
      chk("stream_in_ready", rs, 1'b1);
      if (i >= 3) chk("stream_no_gap", os, 1'b1);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle(1'b0, 8'd0, 8'd0, 1'b1, rs, os);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_count", n_out, 100);

    // Backpressure: three pairs fill the pipe, then in_ready must fall.
    n_out = 0;
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cycle(1'b1, ra, rb, 1'b0, rs, os);
      chk("bp_in_ready", rs, (i < 3) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle(1'b0, 8'd0, 8'd0, 1'b1, rs, os);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count", n_out, 3);

    // Random bubbles on both sides.
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cycle(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), rs, os);
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle(1'b0, 8'd0, 8'd0, 1'b1, rs, os);
    chk("bubble_drained", exp_q.size(), 0);

    // Reset with three pairs in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(20 + i), 8'(30 + i), 1'b1, rs, os);
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_product", out_product, 16'd0);
    exp_q.delete();
    hold_armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b1, rs, os);
      chk("rst_no_stale", os, 1'b0);
    end
    run_one(8'd5, 8'd7, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
